// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending register writes between decode and
// writeback, gates issue on RAW/WAW hazards and in-flight capacity, and
// provides a drain handshake, a stall counter and a sticky protocol-error flag.
module reg_scoreboard #(
   parameter int unsigned NREGS  = 16,
   parameter int unsigned MAXINF = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         id_valid,
   input  logic [NREGS-1:0]             id_req,
   input  logic [NREGS-1:0]             id_prov,
   output logic                         id_ready,
   input  logic                         wb_valid,
   input  logic [NREGS-1:0]             wb_prov,
   input  logic                         flush,
   input  logic                         drain_req,
   output logic                         drain_done,
   output logic [NREGS-1:0]             busy,
   output logic [$clog2(MAXINF+1)-1:0]  inflight,
   output logic [15:0]                  stall_cnt,
   output logic                         err
);

   localparam int unsigned CW = $clog2(MAXINF + 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [NREGS-1:0] r_busy;
   logic [CW-1:0]    r_inflight;
   logic [15:0]      r_stall_cnt;
   logic             r_err;
   logic             r_drain_done;

   logic             w_retire;
   logic [NREGS-1:0] w_free;
   logic             w_hazard;
   logic             w_room;
   logic             w_issue;
   logic             w_ret_cnt;
   logic [NREGS-1:0] w_busy_next;
   logic [CW-1:0]    w_inflight_next;
   logic             w_err_evt;
   logic             w_stall;
   logic             w_empty_next;

   // Writeback bypass: a retiring destination counts as free this cycle
   assign w_retire = wb_valid;
   assign w_free   = r_busy & ~(w_retire ? wb_prov : '0);
   assign w_hazard = |((id_req | id_prov) & w_free);
   assign w_room   = (r_inflight < CW'(MAXINF)) | w_retire;

   // Issue permission; held low while reset is asserted
   assign id_ready = reset & (r_state == S_RUN) & ~flush & ~w_hazard & w_room;
   assign w_issue  = id_valid & id_ready;

   // A retire with nothing in flight is an error and does not move the count
   assign w_ret_cnt   = w_retire & (r_inflight != '0);
   assign w_busy_next = w_free | (w_issue ? id_prov : '0);
   assign w_err_evt   = wb_valid & ((r_inflight == '0) | (|(wb_prov & ~r_busy)));
   assign w_stall     = id_valid & ~id_ready;

   // Next in-flight count: +1 issue only, -1 retire only
   always_comb begin
      w_inflight_next = r_inflight;
      if (w_issue && !w_ret_cnt) begin
         w_inflight_next = r_inflight + CW'(1);
      end else if (!w_issue && w_ret_cnt) begin
         w_inflight_next = r_inflight - CW'(1);
      end
   end

   assign w_empty_next = (w_inflight_next == '0) && (w_busy_next == '0);

   // State, scoreboard, counters and drain FSM; flush overrides all but err/stall
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_RUN;
         r_busy       <= '0;
         r_inflight   <= '0;
         r_stall_cnt  <= '0;
         r_err        <= 1'b0;
         r_drain_done <= 1'b0;
      end else begin
         if (w_err_evt) begin
            r_err <= 1'b1;
         end
         if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (flush) begin
            r_busy       <= '0;
            r_inflight   <= '0;
            r_state      <= S_RUN;
            r_drain_done <= 1'b0;
         end else begin
            r_busy       <= w_busy_next;
            r_inflight   <= w_inflight_next;
            r_drain_done <= 1'b0;
            case (r_state)
               S_RUN: begin
                  if (drain_req) begin
                     r_state <= S_DRAIN;
                  end
               end
               S_DRAIN: begin
                  if (w_empty_next) begin
                     r_state      <= S_DONE;
                     r_drain_done <= 1'b1;
                  end
               end
               S_DONE: begin
                  r_state <= S_RUN;
               end
               default: begin
                  r_state <= S_RUN;
               end
            endcase
         end
      end
   end

   assign busy       = r_busy;
   assign inflight   = r_inflight;
   assign stall_cnt  = r_stall_cnt;
   assign err        = r_err;
   assign drain_done = r_drain_done;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 16, meaning the architectural register count and the width of every register mask.
REQ-002 SHALL have parameter MAXINF, default 4, meaning the maximum number of issued, unretired instructions.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port id_valid  input  1  decode presents an instruction.
REQ-006 SHALL have port id_req  input  NREGS  source-register mask of the decode instruction.
REQ-007 SHALL have port id_prov  input  NREGS  destination-register mask of the decode instruction.
REQ-008 SHALL have port id_ready  output  1  decode instruction issues this cycle when id_valid=1.
REQ-009 SHALL have port wb_valid  input  1  writeback retires one instruction.
REQ-010 SHALL have port wb_prov  input  NREGS  destination mask of the retiring instruction.
REQ-011 SHALL have port flush  input  1  discard all in-flight state.
REQ-012 SHALL have port drain_req  input  1  single-cycle request to empty the pipeline.
REQ-013 SHALL have port drain_done  output  1  single-cycle pulse when a drain completes.
REQ-014 SHALL have port busy  output  NREGS  registered pending-write mask.
REQ-015 SHALL have port inflight  output  $clog2(MAXINF+1)  registered count of issued, unretired instructions.
REQ-016 SHALL have port stall_cnt  output  16  saturating count of stalled decode cycles.
REQ-017 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL define retire = wb_valid, and free = busy & ~(retire ? wb_prov : 0); writeback bypass makes a register free in the cycle it retires.
REQ-019 SHALL define hazard = |((id_req | id_prov) & free), covering RAW and WAW.
REQ-020 SHALL drive id_ready = (state==RUN) & ~flush & ~hazard & (inflight < MAXINF | retire), combinationally.
REQ-021 SHALL define issue = id_valid & id_ready.
REQ-022 SHALL update busy_next = free | (issue ? id_prov : 0); id_prov=0 issues without setting bits.
REQ-023 SHALL update inflight as follows: +1 on issue only, -1 on retire only, unchanged on both or neither.
REQ-024 SHALL ignore a retire when inflight==0, leaving the count at 0 and setting err.
REQ-025 SHALL set err when wb_valid=1 and wb_prov has any bit not set in busy; the busy-clear still applies to the valid bits.
REQ-026 SHALL, when flush=1, load busy=0 and inflight=0 and return to RUN next cycle; flush overrides issue, retire, drain and the state machine; err is unaffected.
REQ-027 SHALL increment stall_cnt each cycle with id_valid=1 & id_ready=0, saturating at 16'hFFFF; flush does not clear it.
REQ-028 SHALL implement FSM states RUN, DRAIN and DONE.
REQ-029 SHALL, in RUN, go to DRAIN when drain_req=1.
REQ-030 SHALL, in DRAIN, hold id_ready=0 and go to DONE when inflight_next==0 and busy_next==0.
REQ-031 SHALL, in DONE, assert drain_done=1 for exactly one cycle and then go to RUN.
REQ-032 SHALL ignore drain_req outside RUN.
REQ-033 SHALL, when a drain is requested with the pipeline already empty, take RUN->DRAIN->DONE, giving drain_done 2 cycles after drain_req.
REQ-034 SHALL treat simultaneous issue and retire of the same register as clearing the old write and setting the new one, leaving the bit set.

Reset
REQ-035 SHALL, while reset=0 (asynchronously), force state=RUN, busy=0, inflight=0, stall_cnt=0, err=0 and drain_done=0.
REQ-036 SHALL keep id_ready=0 while reset=0.
REQ-037 SHALL, on reset assertion mid-drain or mid-stall, abandon the drain without a drain_done pulse.
REQ-038 SHALL make the first issue possible in the first clk edge after reset deassertion.

Verification
REQ-039 SHALL cover a RAW stall: issue prov=0x0002; next cycle id_req=0x0002 -> id_ready=0 and stall_cnt increments; wb_valid with wb_prov=0x0002 -> id_ready=1 in that same cycle; busy=0x0002 afterward (new write).
REQ-040 SHALL cover the capacity limit: 4 issues with disjoint masks -> inflight=4; 5th stalls; retire in the same cycle -> 5th issues and inflight stays 4.
REQ-041 SHALL cover drain: inflight=2, drain_req -> id_ready=0; two retires -> drain_done one cycle after the last retire; then RUN.
REQ-042 SHALL cover flush priority: flush coincident with an issue and a retire -> busy=0 and inflight=0 next cycle, with no issue counted.
REQ-043 SHALL cover errors: retire with inflight=0 -> err=1, inflight stays 0; retire with wb_prov=0x8000 while busy=0x0001 -> err=1 and busy stays 0x0001.
REQ-044 SHALL cover async reset: assert reset=0 between clock edges in DRAIN -> all outputs are at reset values immediately, with no drain_done pulse.
